id_ctrl_decoder: RTL and testbench
==================================

Name: id_ctrl_decoder

Overview:
Registered instruction-decode stage that produces the control bundle consumed downstream, including the aluop/funct3/funct7 triple that feeds the ALU control decoder.
- Decodes a 32-bit RV32I instruction into ALU op class, register indices, sign-extended immediate and datapath enables.
- Sits in the ID/EX pipeline boundary, with stall, flush and load-use hazard handling.

Parameters:
- IMM_W, 32, width of the sign-extended immediate output (>=32).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- inst_i  in  32  instruction from fetch
- inst_valid_i  in  1  inst_i carries a real instruction
- stall_i  in  1  hold all output registers
- flush_i  in  1  kill output (branch mispredict / redirect)
- valid_o  out  1  output bundle holds a real instruction
- aluop_o  out  2  00 RTYPE, 01 ITYPE, 10 LOAD_SAVE, 11 JTYPE
- funct3_o  out  3  inst[14:12]
- funct7_o  out  1  ALU modifier bit (see Behaviour)
- rs1_o, rs2_o, rd_o  out  5 each  register indices
- imm_o  out  IMM_W  sign-extended immediate
- alusrc_o  out  1  ALU operand B = imm
- regwrite_o, memread_o, memwrite_o, memtoreg_o  out  1 each
- branch_o, jal_o, jalr_o  out  1 each
- illegal_o  out  1  unsupported opcode seen (registered)
- hazard_o  out  1  combinational load-use stall request to fetch

Behaviour:
- Reset (rst=1 at clk edge): every registered output = 0. This is a bubble.
- Latency: 1 cycle, inst_i to registered outputs. hazard_o is combinational.
- Next-state priority: rst > flush_i > stall_i > hazard > normal.
  - flush_i: load bubble.
  - stall_i: hold every register.
  - hazard: load bubble.
  - normal: load decoded bundle; if inst_valid_i=0, load bubble.
- Bubble: valid_o=0 and all control/illegal bits 0. Index and imm fields are don't-care but driven 0.
- Opcode decode:
  - 0110011 R: aluop 00, funct7_o=inst[30], regwrite.
  - 0010011 I-ALU: aluop 01, alusrc, regwrite. funct7_o=inst[30] only when funct3=101, else 0.
  - 0000011 LOAD: aluop 10, alusrc, memread, memtoreg, regwrite.
  - 0100011 STORE: aluop 10, alusrc, memwrite. rd_o=0.
  - 1100011 BRANCH: aluop 00, funct7_o=1 (forces SUB), branch. rd_o=0.
  - 1101111 JAL: aluop 11, jal, regwrite. rs1_o=rs2_o=0.
  - 1100111 JALR: aluop 11, alusrc, jalr, regwrite.
  - Other opcodes: bubble controls with illegal_o=1 and valid_o=0.
- Immediate: I/S/B/J formats per RV32I, sign bit inst[31] extended to IMM_W. B and J immediates have bit0=0. R-type imm=0.
- rd=x0: regwrite_o forced 0.
- Load-use hazard, hazard_o=1 when all of:
  - valid_o & memread_o & rd_o≠0,
  - inst_valid_i & !flush_i,
  - rd_o matches a source the incoming instruction uses: rs1 for all except JAL; rs2 for R/STORE/BRANCH only.
- hazard_o is asserted regardless of stall_i. When stall_i=1 the hold wins, and hazard re-evaluates next cycle.
- After one hazard bubble, output is no longer a load, so hazard_o clears and the held instruction issues. Exactly one bubble is inserted per load-use pair.
- flush_i coincident with hazard: bubble, hazard_o=0.

Optional Feature:
HAZARD_DET_EN
- Defined: load-use detection and bubble insertion as above.
- Undefined: hazard_o tied 0, no hazard bubble; forwarding/stall handled externally. All other behaviour identical.

Test Plan:
- Reset then inst 0x002081B3 (add x3,x1,x2), valid → next cycle valid_o=1, aluop 00, funct3 000, funct7_o 0, rd 3, rs1 1, rs2 2, regwrite 1.
- 0x402081B3 (sub) → funct7_o=1. 0x40335293 (srai x5,x6,3) → aluop 01, funct3 101, funct7_o 1, imm 0x403, alusrc 1. 0xFFF00093 (addi x1,x0,-1) → imm 0xFFFFFFFF, funct7_o 0.
- 0x0000A283 (lw x5,0(x1)) then 0x00728333 (add x6,x5,x7):
  - hazard_o=1 in the cycle the add is presented, next output is a bubble;
  - add issues one cycle later (HAZARD_DET_EN defined).
  - Without the macro: no bubble.
- 0x00208463 (beq x1,x2,8) → aluop 00, funct7_o 1, branch 1, imm 8, regwrite 0, rd 0.
- stall_i held 3 cycles after add → outputs unchanged. flush_i together with stall_i → valid_o=0 next cycle.
- Opcode 0110111 (lui) → illegal_o=1, valid_o=0, all enables 0. rst asserted mid-stream → all outputs 0 next edge.

Source files
------------

// File: rtl/id_ctrl_decoder.sv
// RV32I decode stage registered at the ID/EX boundary, with stall, flush and load-use bubble insertion.
// Define HAZARD_DET_EN to enable load-use detection; otherwise hazard_o is tied low.
module id_ctrl_decoder #(
   parameter int IMM_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      inst_i,
   input  logic             inst_valid_i,
   input  logic             stall_i,
   input  logic             flush_i,
   output logic             valid_o,
   output logic [1:0]       aluop_o,
   output logic [2:0]       funct3_o,
   output logic             funct7_o,
   output logic [4:0]       rs1_o,
   output logic [4:0]       rs2_o,
   output logic [4:0]       rd_o,
   output logic [IMM_W-1:0] imm_o,
   output logic             alusrc_o,
   output logic             regwrite_o,
   output logic             memread_o,
   output logic             memwrite_o,
   output logic             memtoreg_o,
   output logic             branch_o,
   output logic             jal_o,
   output logic             jalr_o,
   output logic             illegal_o,
   output logic             hazard_o
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef struct packed {
      logic             valid;
      logic [1:0]       aluop;
      logic [2:0]       funct3;
      logic             funct7;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [4:0]       rd;
      logic [IMM_W-1:0] imm;
      logic             alusrc;
      logic             regwrite;
      logic             memread;
      logic             memwrite;
      logic             memtoreg;
      logic             branch;
      logic             jal;
      logic             jalr;
      logic             illegal;
   } ctrl_t;

   ctrl_t              dec;
   ctrl_t              q;
   logic               hazard;
   logic [6:0]         opcode;
   logic signed [31:0] imm_i;
   logic signed [31:0] imm_s;
   logic signed [31:0] imm_b;
   logic signed [31:0] imm_j;
   logic signed [31:0] imm32;

   assign opcode = inst_i[6:0];
   assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
   assign imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
   assign imm_b  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
   assign imm_j  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

   always_comb begin
      dec        = '0;
      imm32      = '0;
      dec.valid  = 1'b1;
      dec.funct3 = inst_i[14:12];
      dec.rs1    = inst_i[19:15];
      dec.rs2    = inst_i[24:20];
      dec.rd     = inst_i[11:7];
      case (opcode)
         OP_R: begin
            dec.aluop    = 2'b00;
            dec.funct7   = inst_i[30];
            dec.regwrite = 1'b1;
         end
         OP_IALU: begin
            dec.aluop    = 2'b01;
            // only the shift-right pair uses inst[30] to pick arithmetic vs logical
            dec.funct7   = (inst_i[14:12] == 3'b101) ? inst_i[30] : 1'b0;
            dec.alusrc   = 1'b1;
            dec.regwrite = 1'b1;
            imm32        = imm_i;
         end
         OP_LOAD: begin
            dec.aluop    = 2'b10;
            dec.alusrc   = 1'b1;
            dec.memread  = 1'b1;
            dec.memtoreg = 1'b1;
            dec.regwrite = 1'b1;
            imm32        = imm_i;
         end
         OP_STORE: begin
            dec.aluop    = 2'b10;
            dec.alusrc   = 1'b1;
            dec.memwrite = 1'b1;
            dec.rd       = 5'd0;
            imm32        = imm_s;
         end
         OP_BRANCH: begin
            dec.aluop  = 2'b00;
            dec.funct7 = 1'b1;
            dec.branch = 1'b1;
            dec.rd     = 5'd0;
            imm32      = imm_b;
         end
         OP_JAL: begin
            dec.aluop    = 2'b11;
            dec.jal      = 1'b1;
            dec.regwrite = 1'b1;
            dec.rs1      = 5'd0;
            dec.rs2      = 5'd0;
            imm32        = imm_j;
         end
         OP_JALR: begin
            dec.aluop    = 2'b11;
            dec.alusrc   = 1'b1;
            dec.jalr     = 1'b1;
            dec.regwrite = 1'b1;
            imm32        = imm_i;
         end
         default: begin
            dec         = '0;
            dec.illegal = 1'b1;
         end
      endcase
      dec.imm = IMM_W'(imm32);
      if (dec.rd == 5'd0) dec.regwrite = 1'b0;
   end

`ifdef HAZARD_DET_EN
   logic use_rs1;
   logic use_rs2;
   assign use_rs1 = (opcode != OP_JAL);
   assign use_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
   assign hazard  = q.valid && q.memread && (q.rd != 5'd0) && inst_valid_i && !flush_i &&
                    ((use_rs1 && (inst_i[19:15] == q.rd)) || (use_rs2 && (inst_i[24:20] == q.rd)));
`else
   assign hazard = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst)               q <= '0;
      else if (flush_i)      q <= '0;
      else if (stall_i)      q <= q;
      else if (hazard)       q <= '0;
      else if (inst_valid_i) q <= dec;
      else                   q <= '0;
   end

   assign hazard_o   = hazard;
   assign valid_o    = q.valid;
   assign aluop_o    = q.aluop;
   assign funct3_o   = q.funct3;
   assign funct7_o   = q.funct7;
   assign rs1_o      = q.rs1;
   assign rs2_o      = q.rs2;
   assign rd_o       = q.rd;
   assign imm_o      = q.imm;
   assign alusrc_o   = q.alusrc;
   assign regwrite_o = q.regwrite;
   assign memread_o  = q.memread;
   assign memwrite_o = q.memwrite;
   assign memtoreg_o = q.memtoreg;
   assign branch_o   = q.branch;
   assign jal_o      = q.jal;
   assign jalr_o     = q.jalr;
   assign illegal_o  = q.illegal;

endmodule

// File: tb/tb_id_ctrl_decoder.sv
// Self-checking bench for id_ctrl_decoder; expected bundles are queued at drive time and popped after the edge.
// Builds with or without HAZARD_DET_EN.
module tb_id_ctrl_decoder;

   localparam int IMM_W = 32;
`ifdef HAZARD_DET_EN
   localparam logic HZ = 1'b1;
`else
   localparam logic HZ = 1'b0;
`endif

   typedef struct packed {
      logic        valid;
      logic [1:0]  aluop;
      logic [2:0]  funct3;
      logic        funct7;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        alusrc;
      logic        regwrite;
      logic        memread;
      logic        memwrite;
      logic        memtoreg;
      logic        branch;
      logic        jal;
      logic        jalr;
      logic        illegal;
   } bundle_t;

   typedef struct {
      logic [31:0] inst;
      logic        valid;
      logic        stall;
      logic        flush;
      logic        rst;
      logic        hz;
      bundle_t     exp;
   } row_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      inst_i;
   logic             inst_valid_i;
   logic             stall_i;
   logic             flush_i;
   logic             valid_o;
   logic [1:0]       aluop_o;
   logic [2:0]       funct3_o;
   logic             funct7_o;
   logic [4:0]       rs1_o;
   logic [4:0]       rs2_o;
   logic [4:0]       rd_o;
   logic [IMM_W-1:0] imm_o;
   logic             alusrc_o;
   logic             regwrite_o;
   logic             memread_o;
   logic             memwrite_o;
   logic             memtoreg_o;
   logic             branch_o;
   logic             jal_o;
   logic             jalr_o;
   logic             illegal_o;
   logic             hazard_o;

   int      checks = 0;
   int      errors = 0;
   bundle_t sb[$];
   bundle_t act;

   always #5 clk = ~clk;

   id_ctrl_decoder #(.IMM_W(IMM_W)) dut (
      .clk(clk), .rst(rst), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
      .stall_i(stall_i), .flush_i(flush_i), .valid_o(valid_o), .aluop_o(aluop_o),
      .funct3_o(funct3_o), .funct7_o(funct7_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
      .rd_o(rd_o), .imm_o(imm_o), .alusrc_o(alusrc_o), .regwrite_o(regwrite_o),
      .memread_o(memread_o), .memwrite_o(memwrite_o), .memtoreg_o(memtoreg_o),
      .branch_o(branch_o), .jal_o(jal_o), .jalr_o(jalr_o), .illegal_o(illegal_o),
      .hazard_o(hazard_o)
   );

   always_comb begin
      act          = '0;
      act.valid    = valid_o;
      act.aluop    = aluop_o;
      act.funct3   = funct3_o;
      act.funct7   = funct7_o;
      act.rs1      = rs1_o;
      act.rs2      = rs2_o;
      act.rd       = rd_o;
      act.imm      = imm_o;
      act.alusrc   = alusrc_o;
      act.regwrite = regwrite_o;
      act.memread  = memread_o;
      act.memwrite = memwrite_o;
      act.memtoreg = memtoreg_o;
      act.branch   = branch_o;
      act.jal      = jal_o;
      act.jalr     = jalr_o;
      act.illegal  = illegal_o;
   end

   // ctl = {alusrc, regwrite, memread, memwrite, memtoreg, branch, jal, jalr, illegal}
   function automatic bundle_t mk(logic v, logic [1:0] op, logic [2:0] f3, logic f7,
                                  logic [4:0] r1, logic [4:0] r2, logic [4:0] rd,
                                  logic [31:0] imm, logic [8:0] ctl);
      bundle_t b;
      b = '0;
      b.valid = v; b.aluop = op; b.funct3 = f3; b.funct7 = f7;
      b.rs1 = r1; b.rs2 = r2; b.rd = rd; b.imm = imm;
      {b.alusrc, b.regwrite, b.memread, b.memwrite, b.memtoreg,
       b.branch, b.jal, b.jalr, b.illegal} = ctl;
      return b;
   endfunction

   function automatic row_t rw(logic [31:0] inst, logic v, logic st, logic fl, logic r,
                               logic hz, bundle_t e);
      row_t x;
      x.inst = inst; x.valid = v; x.stall = st; x.flush = fl; x.rst = r; x.hz = hz; x.exp = e;
      return x;
   endfunction

   localparam logic [31:0] I_ADD   = 32'h002081B3;
   localparam logic [31:0] I_SUB   = 32'h402081B3;
   localparam logic [31:0] I_ADD0  = 32'h00208033;
   localparam logic [31:0] I_SRAI  = 32'h40335293;
   localparam logic [31:0] I_ADDI  = 32'hFFF00093;
   localparam logic [31:0] I_LW    = 32'h0000A283;
   localparam logic [31:0] I_ADDLU = 32'h00728333;
   localparam logic [31:0] I_SW    = 32'h0050A423;
   localparam logic [31:0] I_BEQ   = 32'h00208463;
   localparam logic [31:0] I_JAL   = 32'h008000EF;
   localparam logic [31:0] I_JALR  = 32'h00408067;
   localparam logic [31:0] I_LUI   = 32'h000002B7;

   bundle_t e_bub, e_add, e_sub, e_add0, e_srai, e_addi, e_lw, e_addlu;
   bundle_t e_sw, e_beq, e_jal, e_jalr, e_ill;

   task automatic drive(row_t r);
      inst_i       = r.inst;
      inst_valid_i = r.valid;
      stall_i      = r.stall;
      flush_i      = r.flush;
      rst          = r.rst;
   endtask

   task automatic test_reset();
      row_t    rows[$];
      bundle_t got;
      rows.push_back(rw(I_ADD, 1, 0, 0, 1, 0, e_bub));
      rows.push_back(rw(I_ADD, 1, 0, 0, 0, 0, e_add));
      foreach (rows[i]) begin
         drive(rows[i]); sb.push_back(rows[i].exp); #1;
         checks++;
         if (hazard_o !== rows[i].hz) begin
            errors++; $display("FAIL reset[%0d] hazard_o actual %b required %b", i, hazard_o, rows[i].hz);
         end
         @(posedge clk); #1;
         got = sb.pop_front(); checks++;
         if (act !== got) begin
            errors++; $display("FAIL reset[%0d] bundle actual %h required %h", i, act, got);
         end
      end
   endtask

   task automatic test_alu();
      row_t    rows[$];
      bundle_t got;
      rows.push_back(rw(I_ADD,  1, 0, 0, 0, 0, e_add));
      rows.push_back(rw(I_SUB,  1, 0, 0, 0, 0, e_sub));
      rows.push_back(rw(I_ADD0, 1, 0, 0, 0, 0, e_add0));
      rows.push_back(rw(I_SRAI, 1, 0, 0, 0, 0, e_srai));
      rows.push_back(rw(I_ADDI, 1, 0, 0, 0, 0, e_addi));
      foreach (rows[i]) begin
         drive(rows[i]); sb.push_back(rows[i].exp); #1;
         checks++;
         if (hazard_o !== rows[i].hz) begin
            errors++; $display("FAIL alu[%0d] hazard_o actual %b required %b", i, hazard_o, rows[i].hz);
         end
         @(posedge clk); #1;
         got = sb.pop_front(); checks++;
         if (act !== got) begin
            errors++; $display("FAIL alu[%0d] bundle actual %h required %h", i, act, got);
         end
      end
   endtask

   task automatic test_mem_ctrl();
      row_t    rows[$];
      bundle_t got;
      rows.push_back(rw(I_SW,   1, 0, 0, 0, 0, e_sw));
      rows.push_back(rw(I_LW,   1, 0, 0, 0, 0, e_lw));
      rows.push_back(rw(I_BEQ,  1, 0, 0, 0, 0, e_beq));
      rows.push_back(rw(I_JAL,  1, 0, 0, 0, 0, e_jal));
      rows.push_back(rw(I_JALR, 1, 0, 0, 0, 0, e_jalr));
      foreach (rows[i]) begin
         drive(rows[i]); sb.push_back(rows[i].exp); #1;
         checks++;
         if (hazard_o !== rows[i].hz) begin
            errors++; $display("FAIL mem_ctrl[%0d] hazard_o actual %b required %b", i, hazard_o, rows[i].hz);
         end
         @(posedge clk); #1;
         got = sb.pop_front(); checks++;
         if (act !== got) begin
            errors++; $display("FAIL mem_ctrl[%0d] bundle actual %h required %h", i, act, got);
         end
      end
   endtask

   task automatic test_load_use();
      row_t    rows[$];
      bundle_t got;
      // plain load-use pair: one bubble, then the held add issues
      rows.push_back(rw(I_LW,    1, 0, 0, 0, 0,  e_lw));
      rows.push_back(rw(I_ADDLU, 1, 0, 0, 0, HZ, HZ ? e_bub : e_addlu));
`ifdef HAZARD_DET_EN
      rows.push_back(rw(I_ADDLU, 1, 0, 0, 0, 0,  e_addlu));
`endif
      // stall wins over hazard, hazard re-raised once stall drops
      rows.push_back(rw(I_LW,    1, 0, 0, 0, 0,  e_lw));
      rows.push_back(rw(I_ADDLU, 1, 1, 0, 0, HZ, e_lw));
      rows.push_back(rw(I_ADDLU, 1, 0, 0, 0, HZ, HZ ? e_bub : e_addlu));
`ifdef HAZARD_DET_EN
      rows.push_back(rw(I_ADDLU, 1, 0, 0, 0, 0,  e_addlu));
`endif
      // flush with a dependent instruction: no hazard, bubble
      rows.push_back(rw(I_LW,    1, 0, 0, 0, 0,  e_lw));
      rows.push_back(rw(I_ADDLU, 1, 0, 1, 0, 0,  e_bub));
      // independent instruction after a load, and an invalid dependent one
      rows.push_back(rw(I_LW,    1, 0, 0, 0, 0,  e_lw));
      rows.push_back(rw(I_ADDLU, 0, 0, 0, 0, 0,  e_bub));
      rows.push_back(rw(I_LW,    1, 0, 0, 0, 0,  e_lw));
      rows.push_back(rw(I_ADD,   1, 0, 0, 0, 0,  e_add));
      foreach (rows[i]) begin
         drive(rows[i]); sb.push_back(rows[i].exp); #1;
         checks++;
         if (hazard_o !== rows[i].hz) begin
            errors++; $display("FAIL load_use[%0d] hazard_o actual %b required %b", i, hazard_o, rows[i].hz);
         end
         @(posedge clk); #1;
         got = sb.pop_front(); checks++;
         if (act !== got) begin
            errors++; $display("FAIL load_use[%0d] bundle actual %h required %h", i, act, got);
         end
      end
   endtask

   task automatic test_stall_flush();
      row_t    rows[$];
      bundle_t got;
      rows.push_back(rw(I_ADD, 1, 0, 0, 0, 0, e_add));
      rows.push_back(rw(I_SUB, 1, 1, 0, 0, 0, e_add));
      rows.push_back(rw(I_SUB, 1, 1, 0, 0, 0, e_add));
      rows.push_back(rw(I_SUB, 1, 1, 0, 0, 0, e_add));
      rows.push_back(rw(I_SUB, 1, 1, 1, 0, 0, e_bub));
      rows.push_back(rw(I_SUB, 1, 0, 0, 0, 0, e_sub));
      rows.push_back(rw(I_SUB, 1, 0, 1, 0, 0, e_bub));
      foreach (rows[i]) begin
         drive(rows[i]); sb.push_back(rows[i].exp); #1;
         checks++;
         if (hazard_o !== rows[i].hz) begin
            errors++; $display("FAIL stall_flush[%0d] hazard_o actual %b required %b", i, hazard_o, rows[i].hz);
         end
         @(posedge clk); #1;
         got = sb.pop_front(); checks++;
         if (act !== got) begin
            errors++; $display("FAIL stall_flush[%0d] bundle actual %h required %h", i, act, got);
         end
      end
   endtask

   task automatic test_illegal_reset();
      row_t    rows[$];
      bundle_t got;
      rows.push_back(rw(I_LUI,  1, 0, 0, 0, 0, e_ill));
      rows.push_back(rw(I_ADD,  0, 0, 0, 0, 0, e_bub));
      rows.push_back(rw(I_ADDI, 1, 0, 0, 0, 0, e_addi));
      rows.push_back(rw(I_ADD,  1, 0, 0, 1, 0, e_bub));
      rows.push_back(rw(I_SRAI, 1, 0, 0, 0, 0, e_srai));
      rows.push_back(rw(I_ADD,  1, 1, 0, 1, 0, e_bub));
      foreach (rows[i]) begin
         drive(rows[i]); sb.push_back(rows[i].exp); #1;
         checks++;
         if (hazard_o !== rows[i].hz) begin
            errors++; $display("FAIL illegal_reset[%0d] hazard_o actual %b required %b", i, hazard_o, rows[i].hz);
         end
         @(posedge clk); #1;
         got = sb.pop_front(); checks++;
         if (act !== got) begin
            errors++; $display("FAIL illegal_reset[%0d] bundle actual %h required %h", i, act, got);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      e_bub   = '0;
      e_add   = mk(1, 2'b00, 3'd0, 1'b0, 5'd1, 5'd2,  5'd3, 32'h0,        9'b010000000);
      e_sub   = mk(1, 2'b00, 3'd0, 1'b1, 5'd1, 5'd2,  5'd3, 32'h0,        9'b010000000);
      e_add0  = mk(1, 2'b00, 3'd0, 1'b0, 5'd1, 5'd2,  5'd0, 32'h0,        9'b000000000);
      e_srai  = mk(1, 2'b01, 3'd5, 1'b1, 5'd6, 5'd3,  5'd5, 32'h403,      9'b110000000);
      e_addi  = mk(1, 2'b01, 3'd0, 1'b0, 5'd0, 5'd31, 5'd1, 32'hFFFFFFFF, 9'b110000000);
      e_lw    = mk(1, 2'b10, 3'd2, 1'b0, 5'd1, 5'd0,  5'd5, 32'h0,        9'b111010000);
      e_addlu = mk(1, 2'b00, 3'd0, 1'b0, 5'd5, 5'd7,  5'd6, 32'h0,        9'b010000000);
      e_sw    = mk(1, 2'b10, 3'd2, 1'b0, 5'd1, 5'd5,  5'd0, 32'h8,        9'b100100000);
      e_beq   = mk(1, 2'b00, 3'd0, 1'b1, 5'd1, 5'd2,  5'd0, 32'h8,        9'b000001000);
      e_jal   = mk(1, 2'b11, 3'd0, 1'b0, 5'd0, 5'd0,  5'd1, 32'h8,        9'b010000100);
      e_jalr  = mk(1, 2'b11, 3'd0, 1'b0, 5'd1, 5'd4,  5'd0, 32'h4,        9'b100000010);
      e_ill   = mk(0, 2'b00, 3'd0, 1'b0, 5'd0, 5'd0,  5'd0, 32'h0,        9'b000000001);

      rst = 1'b1; inst_i = '0; inst_valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
      @(posedge clk); #1;

      test_reset();
      test_alu();
      test_mem_ctrl();
      test_load_use();
      test_stall_flush();
      test_illegal_reset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
